bram_block_ctrl: RTL and testbench
==================================

// Module: bram_block_ctrl
// PURPOSE
// Sequencer in front of the banked BRAM block (BANK_CNT banks, shared write address and din, per-bank wr_en).
// Accepts full-width masked write requests and full-width read requests over valid/ready.
// Serialises each write into one bank write per cycle on the shared din bus.
// Returns read data with fixed latency and stalls reads that hit a write still in progress.
// PARAMETERS
// BRAM_ADDR_WIDTH  10  word address width, shared by all banks
// BANK_DATA_WIDTH  8   width of one bank and of the shared din bus
// BANK_CNT         4   number of banks; also write-mask width
// BRAM_DATA_WIDTH  BANK_DATA_WIDTH*BANK_CNT  full word width (derived; do not override)
// PORTS
// clock          in   1                clock; all state changes on its rising edge
// reset_n        in   1                asynchronous, active-low reset
// wr_valid       in   1                write request valid
// wr_ready       out  1                write request accepted when wr_valid && wr_ready
// wr_addr        in   BRAM_ADDR_WIDTH  write word address
// wr_data        in   BRAM_DATA_WIDTH  write word; bank i = bits [i*BANK_DATA_WIDTH +: BANK_DATA_WIDTH]
// wr_mask        in   BANK_CNT         bit i=1 -> bank i is written
// rd_valid       in   1                read request valid
// rd_ready       out  1                read request accepted when rd_valid && rd_ready
// rd_addr        in   BRAM_ADDR_WIDTH  read word address
// rsp_valid      out  1                read response valid (single-cycle pulse; no backpressure)
// rsp_data       out  BRAM_DATA_WIDTH  read response word; bank i in slice i
// busy           out  1                write sequence in progress
// bram_wr_addr   out  BRAM_ADDR_WIDTH  to block wr_addr (registered)
// bram_wr_en     out  BANK_CNT         to block wr_en; one-hot or zero (registered)
// bram_din       out  BANK_DATA_WIDTH  to block din (registered)
// bram_rd_addr   out  BRAM_ADDR_WIDTH  to block rd_addr (registered)
// bram_dout      in   BRAM_DATA_WIDTH  from block dout; valid 1 cycle after bram_rd_addr changes
// BEHAVIOUR
// - Reset (asynchronous, takes effect immediately): state=IDLE; bram_wr_en=0; bram_wr_addr, bram_din,
//   bram_rd_addr=0; rsp_valid=0; busy=0. Pending mask, data and read pipeline are cleared.
// - Write FSM states:
//   IDLE: wr_ready=1. On accept, latch addr, data and mask.
//     mask!=0 -> WRITE.
//     mask==0 -> stay in IDLE; no bank is written; request is consumed.
//   WRITE: wr_ready=0; busy=1. Each cycle, drive bram_wr_en one-hot for the lowest set bit of the
//     pending mask, drive bram_din=slice of that bank and bram_wr_addr=latched addr; then clear that mask bit.
//     The cycle that issues the last set bit returns the FSM to IDLE.
// - Write occupancy = popcount(mask) cycles of bram_wr_en activity, starting the cycle after accept.
//   Next accept is possible the cycle after the last bank write, so minimum throughput is popcount+1 cycles per write.
// - Read: rd_ready = !(busy && rd_addr==latched wr addr). Reads to any other address proceed during a write.
// - On read accept, bram_rd_addr <= rd_addr. rsp_valid=1 and rsp_data=bram_dout exactly 2 cycles after the accept edge.
// - Back-to-back reads are accepted every cycle; responses return in request order.
// - Simultaneous read and write accept in IDLE to the same address: the read returns the OLD data
//   (it was accepted before the write became busy).
// - Address wrap-around is not special-cased; addresses are used as given.
// - bram_wr_en never has more than one bit set.
// TESTING
// - Reset, then idle 5 cycles -> wr_ready=1, rd_ready=1, bram_wr_en=0, rsp_valid=0, busy=0 throughout.
// - Write addr=0x010, data=0xDDCCBBAA, mask=4'b1111 -> bram_wr_en = 0001,0010,0100,1000 on consecutive cycles
//   with din = AA,BB,CC,DD; wr_ready low for 4 cycles; then read 0x010 -> rsp_data=0xDDCCBBAA 2 cycles after accept.
// - Write addr=0x010, data=0x11223344, mask=4'b0101 -> exactly 2 bank writes (din 44 then 22);
//   then read 0x010 -> 0xDD22BB44. A write with mask=0 -> no bram_wr_en activity and wr_ready stays high.
// - During the 0x010 write, read 0x010 -> rd_ready=0 until busy drops, then response has the new data.
//   A read of 0x011 during the same write is accepted immediately.
// - Reads of 0x000..0x007 on consecutive cycles -> 8 consecutive rsp_valid pulses carrying the data in order.
// - Assert reset_n low in the 2nd cycle of WRITE -> bram_wr_en=0 immediately; after release, state is IDLE,
//   no further bank writes occur, and banks not yet written keep their old contents.

Source files
------------

// File: rtl/bram_block_ctrl.sv
// Request sequencer for a banked BRAM: serialises masked full-width writes into one bank
// write per cycle on a shared din bus and returns full-width reads with a fixed 2-cycle latency.
module bram_block_ctrl #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BANK_DATA_WIDTH = 8,
    parameter int BANK_CNT        = 4,
    parameter int BRAM_DATA_WIDTH = BANK_DATA_WIDTH * BANK_CNT
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [BRAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] wr_data,
    input  logic [BANK_CNT-1:0]        wr_mask,
    input  logic                       rd_valid,
    output logic                       rd_ready,
    input  logic [BRAM_ADDR_WIDTH-1:0] rd_addr,
    output logic                       rsp_valid,
    output logic [BRAM_DATA_WIDTH-1:0] rsp_data,
    output logic                       busy,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [BANK_CNT-1:0]        bram_wr_en,
    output logic [BANK_DATA_WIDTH-1:0] bram_din,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_dout
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                     state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BRAM_DATA_WIDTH-1:0] data_q, data_d;
    logic [BANK_CNT-1:0]        mask_q, mask_d;
    logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr_q, bram_wr_addr_d;
    logic [BANK_CNT-1:0]        bram_wr_en_q, bram_wr_en_d;
    logic [BANK_DATA_WIDTH-1:0] bram_din_q, bram_din_d;
    logic [BRAM_ADDR_WIDTH-1:0] bram_rd_addr_q, bram_rd_addr_d;
    logic                       rd_vld_p0_q, rd_vld_p1_q;
    logic                       rsp_valid_q;
    logic [BRAM_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [BANK_CNT-1:0]        issue;
    logic                       rd_fire;

    function automatic logic [BANK_CNT-1:0] lowest_bit(input logic [BANK_CNT-1:0] m);
        return m & (~m + {{(BANK_CNT-1){1'b0}}, 1'b1});
    endfunction

    function automatic logic [BANK_DATA_WIDTH-1:0] bank_slice(
        input logic [BRAM_DATA_WIDTH-1:0] d,
        input logic [BANK_CNT-1:0]        onehot
    );
        logic [BANK_DATA_WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < BANK_CNT; i++) begin
            if (onehot[i]) s = d[i*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
        end
        return s;
    endfunction

    assign wr_ready = (state_q == IDLE);
    assign busy     = (state_q == WRITE);
    // A read may only be held off by a write that is still landing at the same word.
    assign rd_ready = !(busy && (rd_addr == addr_q));
    assign rd_fire  = rd_valid && rd_ready;

    // The first bank write is issued straight from the request so it lands the cycle after accept.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        data_d         = data_q;
        mask_d         = mask_q;
        bram_wr_en_d   = '0;
        bram_din_d     = bram_din_q;
        bram_wr_addr_d = bram_wr_addr_q;
        issue          = '0;
        case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    issue  = lowest_bit(wr_mask);
                    addr_d = wr_addr;
                    data_d = wr_data;
                    mask_d = wr_mask & ~issue;
                    if (wr_mask != '0) begin
                        state_d        = WRITE;
                        bram_wr_en_d   = issue;
                        bram_din_d     = bank_slice(wr_data, issue);
                        bram_wr_addr_d = wr_addr;
                    end
                end
            end
            WRITE: begin
                issue = lowest_bit(mask_q);
                if (mask_q == '0) begin
                    state_d = IDLE;
                end else begin
                    bram_wr_en_d = issue;
                    bram_din_d   = bank_slice(data_q, issue);
                    mask_d       = mask_q & ~issue;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bram_rd_addr_d = rd_fire ? rd_addr : bram_rd_addr_q;
        rsp_data_d     = rd_vld_p1_q ? bram_dout : rsp_data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            data_q         <= '0;
            mask_q         <= '0;
            bram_wr_addr_q <= '0;
            bram_wr_en_q   <= '0;
            bram_din_q     <= '0;
            bram_rd_addr_q <= '0;
            rd_vld_p0_q    <= 1'b0;
            rd_vld_p1_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            mask_q         <= mask_d;
            bram_wr_addr_q <= bram_wr_addr_d;
            bram_wr_en_q   <= bram_wr_en_d;
            bram_din_q     <= bram_din_d;
            // p0: address presented to the block
            bram_rd_addr_q <= bram_rd_addr_d;
            rd_vld_p0_q    <= rd_fire;
            // p1: block dout valid
            rd_vld_p1_q    <= rd_vld_p0_q;
            // p2: response registered
            rsp_valid_q    <= rd_vld_p1_q;
            rsp_data_q     <= rsp_data_d;
        end
    end

    assign bram_wr_addr = bram_wr_addr_q;
    assign bram_wr_en   = bram_wr_en_q;
    assign bram_din     = bram_din_q;
    assign bram_rd_addr = bram_rd_addr_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_bram_block_ctrl.sv
// Bench for bram_block_ctrl: banked BRAM model plus a word-level reference memory and
// expected-event queues, driven by directed steps followed by a random phase.
module tb_bram_block_ctrl;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int BC = 4;
    localparam int WW = DW * BC;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [WW-1:0] wr_data;
    logic [BC-1:0] wr_mask;
    logic          rsp_valid, busy;
    logic [WW-1:0] rsp_data, bram_dout;
    logic [AW-1:0] bram_wr_addr, bram_rd_addr;
    logic [BC-1:0] bram_wr_en;
    logic [DW-1:0] bram_din;

    logic          init_en;
    logic [5:0]    init_addr;
    logic [WW-1:0] init_data;

    always #5 clock = ~clock;

    bram_block_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .bram_wr_addr(bram_wr_addr), .bram_wr_en(bram_wr_en), .bram_din(bram_din),
        .bram_rd_addr(bram_rd_addr), .bram_dout(bram_dout)
    );

    // Banked block: registered read-first dout, per-bank write enables, backdoor preload port.
    logic [DW-1:0] mem [BC][64];
    always @(posedge clock) begin
        for (int i = 0; i < BC; i++) begin
            if (init_en) mem[i][init_addr] <= init_data[i*DW +: DW];
            else if (bram_wr_en[i]) mem[i][bram_wr_addr[5:0]] <= bram_din;
            bram_dout[i*DW +: DW] <= mem[i][bram_rd_addr[5:0]];
        end
    end

    typedef struct { logic [WW-1:0] data; int due; } rsp_t;
    typedef struct { logic [BC-1:0] en; logic [DW-1:0] din; logic [AW-1:0] addr; int due; } wev_t;

    logic [WW-1:0] ref_mem [64];
    rsp_t          rq[$];
    wev_t          wq[$];
    int            cyc, total, passed, failed, rsp_pulses, st;
    logic          last_rfire;
    logic [WW-1:0] last_rsp, old_word;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs were set at the previous negedge; outputs checked at the next negedge.
    task automatic tick();
        logic eb, erd, wf, rf;
        int   d;
        wev_t ev;
        #1;
        eb  = 1'b0;
        erd = 1'b1;
        if (wq.size() > 0) begin
            eb = (wq[0].due == cyc);
            if (eb && rd_addr == wq[0].addr) erd = 1'b0;
        end
        chk("rd_ready", 64'(rd_ready), 64'(erd));
        wf = wr_valid && !eb;
        rf = rd_valid && erd;
        @(posedge clock);
        cyc++;
        while (wq.size() > 0 && wq[0].due == cyc - 1) begin
            for (int i = 0; i < BC; i++)
                if (wq[0].en[i]) ref_mem[wq[0].addr[5:0]][i*DW +: DW] = wq[0].din;
            void'(wq.pop_front());
        end
        last_rfire = rf;
        if (rf) rq.push_back('{ref_mem[rd_addr[5:0]], cyc + 2});
        if (wf) begin
            d = cyc;
            for (int i = 0; i < BC; i++) begin
                if (wr_mask[i]) begin
                    ev.en   = '0;
                    ev.en[i] = 1'b1;
                    ev.din  = wr_data[i*DW +: DW];
                    ev.addr = wr_addr;
                    ev.due  = d;
                    wq.push_back(ev);
                    d++;
                end
            end
        end
        @(negedge clock);
        eb = (wq.size() > 0) && (wq[0].due == cyc);
        chk("busy", 64'(busy), 64'(eb));
        chk("wr_ready", 64'(wr_ready), 64'(!eb));
        if (eb) begin
            chk("wr_en", 64'(bram_wr_en), 64'(wq[0].en));
            chk("din", 64'(bram_din), 64'(wq[0].din));
            chk("wr_addr", 64'(bram_wr_addr), 64'(wq[0].addr));
        end else begin
            chk("wr_en_idle", 64'(bram_wr_en), 64'(0));
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rsp_valid", 64'(rsp_valid), 64'(1));
            chk("rsp_data", 64'(rsp_data), 64'(rq[0].data));
            last_rsp = rsp_data;
            rsp_pulses++;
            void'(rq.pop_front());
        end else begin
            chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read_wait(input logic [AW-1:0] a, output int stalls);
        rd_valid = 1'b1;
        rd_addr  = a;
        stalls   = 0;
        tick();
        while (!last_rfire && stalls < 20) begin
            stalls++;
            tick();
        end
        rd_valid = 1'b0;
        chk("rd_accept_bound", 64'(last_rfire), 64'(1));
    endtask

    task automatic write_req(input logic [AW-1:0] a, input logic [WW-1:0] d, input logic [BC-1:0] m);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_mask  = m;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; passed = 0; failed = 0; cyc = 0; rsp_pulses = 0;
        last_rfire = 1'b0; last_rsp = '0;
        reset_n = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_valid = 1'b0; rd_addr = '0;
        init_en = 1'b0; init_addr = '0; init_data = '0;

        @(negedge clock);
        for (int a = 0; a < 64; a++) begin
            init_en   = 1'b1;
            init_addr = 6'(a);
            init_data = $urandom;
            ref_mem[a] = init_data;
            @(negedge clock);
        end
        init_en = 1'b0;

        chk("rst_wr_en", 64'(bram_wr_en), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_wr_addr", 64'(bram_wr_addr), 64'(0));
        chk("rst_din", 64'(bram_din), 64'(0));
        chk("rst_rd_addr", 64'(bram_rd_addr), 64'(0));
        reset_n = 1'b1;

        ticks(5);

        write_req(10'h010, 32'hDDCCBBAA, 4'b1111);
        ticks(5);
        read_wait(10'h010, st);
        chk("full_write_stall", 64'(st), 64'(0));
        ticks(3);
        chk("full_write_read", 64'(last_rsp), 64'(32'hDDCCBBAA));

        write_req(10'h010, 32'h11223344, 4'b0101);
        read_wait(10'h010, st);
        chk("same_addr_stall", 64'(st), 64'(2));
        ticks(3);
        chk("partial_write_read", 64'(last_rsp), 64'(32'hDD22BB44));

        write_req(10'h010, 32'h55667788, 4'b1111);
        read_wait(10'h011, st);
        chk("other_addr_no_stall", 64'(st), 64'(0));
        ticks(6);

        write_req(10'h011, 32'hFFFFFFFF, 4'b0000);
        chk("mask0_wr_ready", 64'(wr_ready), 64'(1));
        chk("mask0_busy", 64'(busy), 64'(0));
        ticks(2);

        rsp_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1;
            rd_addr  = AW'(i);
            tick();
            chk("b2b_accept", 64'(last_rfire), 64'(1));
        end
        rd_valid = 1'b0;
        ticks(3);
        chk("b2b_pulses", 64'(rsp_pulses), 64'(8));

        old_word = ref_mem[6'h10];
        rd_valid = 1'b1;
        rd_addr  = 10'h010;
        write_req(10'h010, 32'h0BADF00D, 4'b1111);
        chk("simul_rd_accept", 64'(last_rfire), 64'(1));
        rd_valid = 1'b0;
        ticks(6);
        chk("simul_rd_old", 64'(last_rsp), 64'(old_word));

        old_word = ref_mem[6'h20];
        write_req(10'h020, 32'hA1B2C3D4, 4'b1111);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_wr_en", 64'(bram_wr_en), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_wr_ready", 64'(wr_ready), 64'(1));
        wq.delete();
        rq.delete();
        @(posedge clock);
        cyc++;
        @(negedge clock);
        reset_n = 1'b1;
        ticks(4);
        read_wait(10'h020, st);
        ticks(3);
        chk("rst_mid_contents", 64'(last_rsp), 64'({old_word[31:8], 8'hD4}));

        for (int k = 0; k < 300; k++) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr  = AW'($urandom_range(0, 15));
            wr_data  = $urandom;
            wr_mask  = BC'($urandom);
            rd_valid = 1'($urandom_range(0, 1));
            rd_addr  = AW'($urandom_range(0, 15));
            tick();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        ticks(8);
        chk("drain_rsp", 64'(rq.size()), 64'(0));
        chk("drain_wr", 64'(wq.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
